// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text-console writer.
// Holds the screen geometry defaults, index widths, control-code constants,
// the writer state enum and the packed write-port record.
package vga_pkg;

  localparam int DEF_ROWS = 30;
  localparam int DEF_COLS = 70;
  localparam int ROW_W    = 5;
  localparam int COL_W    = 7;
  localparam int COLOR_W  = 3;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    S_CLR_ALL  = 2'd0,
    S_IDLE     = 2'd1,
    S_CLR_LINE = 2'd2
  } term_state_t;

  // One character-memory write: address, glyph and colours.
  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [7:0]         ascii;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
  } cell_wr_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  // A blanked cell is a space drawn in the background colour on itself.
  function automatic cell_wr_t blank_cell(input logic [ROW_W-1:0]   row,
                                          input logic [COL_W-1:0]   col,
                                          input logic [COLOR_W-1:0] bg);
    cell_wr_t c;
    c.row   = row;
    c.col   = col;
    c.ascii = ASCII_SP;
    c.fg    = bg;
    c.bg    = bg;
    return c;
  endfunction

endpackage

// File: rtl/vga_term_writer.sv
// Text-console writer: turns a byte stream into character-memory writes with cursor, wrap, BS, CR/LF and clears.
// Latency: a byte accepted at edge T shows its write and cursor update in the cycle after T; clears run one cell per cycle.
// Backpressure: in_ready drops for the whole of a line/screen clear and returns the cycle after the last clear write.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset (restarts a full-screen clear)
//   in_valid/in_ready/in_ascii byte input handshake; fg_color/bg_color sampled on accept
//   we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color   character-memory write port
//   cur_row, cur_col          cursor position for the overlay
//   busy                      a clear is in progress
module vga_term_writer
  import vga_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_ascii,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               we,
  output logic [ROW_W-1:0]   wr_addr,
  output logic [COL_W-1:0]   wc_addr,
  output logic [7:0]         w_ascii,
  output logic [COLOR_W-1:0] w_fg_color,
  output logic [COLOR_W-1:0] w_bg_color,
  output logic [ROW_W-1:0]   cur_row,
  output logic [COL_W-1:0]   cur_col,
  output logic               busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  term_state_t        state_q,   state_d;
  logic [ROW_W-1:0]   clr_row_q, clr_row_d;
  logic [COL_W-1:0]   clr_col_q, clr_col_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [COLOR_W-1:0] bg_lat_q,  bg_lat_d;
  logic               we_q,      we_d;
  cell_wr_t           wr_q,      wr_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;
  logic               accept;

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    bg_lat_d  = bg_lat_q;
    we_d      = 1'b0;
    wr_d      = wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          bg_lat_d = bg_color;
          if (is_printable(in_ascii)) begin
            we_d     = 1'b1;
            wr_d.row   = cur_row_q;
            wr_d.col   = cur_col_q;
            wr_d.ascii = in_ascii;
            wr_d.fg    = fg_color;
            wr_d.bg    = bg_color;
            if (cur_col_q < LAST_COL) begin
              cur_col_d = cur_col_q + COL_ONE;
            end else begin
              cur_col_d = '0;
              if (cur_row_q < LAST_ROW) begin
                cur_row_d = cur_row_q + ROW_ONE;
              end else begin
                // The character write occupies this cycle, so the row-0
                // clear starts from column 0 on the next one.
                cur_row_d = '0;
                state_d   = S_CLR_LINE;
                clr_row_d = '0;
                clr_col_d = '0;
              end
            end
          end else if (in_ascii == ASCII_LF) begin
            cur_col_d = '0;
            if (cur_row_q < LAST_ROW) begin
              cur_row_d = cur_row_q + ROW_ONE;
            end else begin
              // No character to write, so column 0 is blanked right away.
              cur_row_d = '0;
              state_d   = S_CLR_LINE;
              we_d      = 1'b1;
              wr_d      = blank_cell('0, '0, bg_color);
              clr_row_d = '0;
              clr_col_d = COL_ONE;
            end
          end else if (in_ascii == ASCII_CR) begin
            cur_col_d = '0;
          end else if (in_ascii == ASCII_BS) begin
            if (cur_col_q != '0) begin
              cur_col_d  = cur_col_q - COL_ONE;
              we_d       = 1'b1;
              wr_d.row   = cur_row_q;
              wr_d.col   = cur_col_q - COL_ONE;
              wr_d.ascii = ASCII_SP;
              wr_d.fg    = fg_color;
              wr_d.bg    = bg_color;
            end
          end else if (in_ascii == ASCII_FF) begin
            // Cell (0,0) is blanked in the accept cycle; the sweep resumes at (0,1).
            state_d   = S_CLR_ALL;
            we_d      = 1'b1;
            wr_d      = blank_cell('0, '0, bg_color);
            clr_row_d = '0;
            clr_col_d = COL_ONE;
          end
        end
      end

      S_CLR_LINE: begin
        we_d = 1'b1;
        wr_d = blank_cell(clr_row_q, clr_col_q, bg_lat_q);
        if (clr_col_q == LAST_COL) begin
          state_d   = S_IDLE;
          clr_col_d = '0;
        end else begin
          clr_col_d = clr_col_q + COL_ONE;
        end
      end

      S_CLR_ALL: begin
        we_d = 1'b1;
        wr_d = blank_cell(clr_row_q, clr_col_q, bg_lat_q);
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          if (clr_row_q == LAST_ROW) begin
            state_d   = S_IDLE;
            clr_row_d = '0;
            cur_row_d = '0;
            cur_col_d = '0;
          end else begin
            clr_row_d = clr_row_q + ROW_ONE;
          end
        end else begin
          clr_col_d = clr_col_q + COL_ONE;
        end
      end

      default: begin
        state_d   = S_CLR_ALL;
        clr_row_d = '0;
        clr_col_d = '0;
      end
    endcase

    // Ready only after a full cycle back in idle, so it rises the cycle
    // after the final clear write rather than alongside it.
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLR_ALL;
      clr_row_q <= '0;
      clr_col_q <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      bg_lat_q  <= '0;
      we_q      <= 1'b0;
      wr_q      <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      bg_lat_q  <= bg_lat_d;
      we_q      <= we_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign we         = we_q;
  assign wr_addr    = wr_q.row;
  assign wc_addr    = wr_q.col;
  assign w_ascii    = wr_q.ascii;
  assign w_fg_color = wr_q.fg;
  assign w_bg_color = wr_q.bg;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer: reset clear, text, wrap, CR/LF, BS, screen wrap, form feed and reset abort.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Every comparison goes through check(); one summary line closes the run.
module tb_vga_term_writer;
  import vga_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_ascii;
  logic [COLOR_W-1:0] fg_color;
  logic [COLOR_W-1:0] bg_color;
  logic               we;
  logic [ROW_W-1:0]   wr_addr;
  logic [COL_W-1:0]   wc_addr;
  logic [7:0]         w_ascii;
  logic [COLOR_W-1:0] w_fg_color;
  logic [COLOR_W-1:0] w_bg_color;
  logic [ROW_W-1:0]   cur_row;
  logic [COL_W-1:0]   cur_col;
  logic               busy;

  int errors = 0;
  int checks = 0;

  vga_term_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ascii   (in_ascii),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .we         (we),
    .wr_addr    (wr_addr),
    .wc_addr    (wc_addr),
    .w_ascii    (w_ascii),
    .w_fg_color (w_fg_color),
    .w_bg_color (w_bg_color),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cur(input string tag, input int r, input int c);
    check({tag, "_cur_row"}, 32'(cur_row), 32'(r));
    check({tag, "_cur_col"}, 32'(cur_col), 32'(c));
  endtask

  task automatic check_wr(input string tag, input int r, input int c, input logic [7:0] a);
    check({tag, "_we"},    32'(we),      32'd1);
    check({tag, "_row"},   32'(wr_addr), 32'(r));
    check({tag, "_col"},   32'(wc_addr), 32'(c));
    check({tag, "_ascii"}, 32'(w_ascii), 32'(a));
  endtask

  // Presents a byte, waits (bounded) for ready, then clocks the accept edge.
  task automatic send(input logic [7:0] b, input logic [2:0] f, input logic [2:0] g);
    int n;
    n        = 0;
    in_ascii = b;
    fg_color = f;
    bg_color = g;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Watches a clear from the current cycle (index 0) until in_ready rises.
  // row_exp < 0 means any row may be written.
  task automatic run_clear(input string tag, input int n_exp, input logic [2:0] bg_exp,
                           input int row_exp, input int first_exp);
    bit seen [DEF_ROWS][DEF_COLS];
    int nwr, first, last, distinct, bad, rdy_bad, rdy_idx;
    nwr = 0; first = -1; last = -1; distinct = 0; bad = 0; rdy_bad = 0; rdy_idx = -1;
    foreach (seen[r, c]) seen[r][c] = 1'b0;
    for (int idx = 0; idx < 2400; idx++) begin
      if (we === 1'b1) begin
        if (first < 0) first = idx;
        last = idx;
        nwr++;
        if (w_ascii !== ASCII_SP || w_fg_color !== bg_exp || w_bg_color !== bg_exp) bad++;
        if (row_exp >= 0 && int'(wr_addr) != row_exp) bad++;
        if (int'(wr_addr) < DEF_ROWS && int'(wc_addr) < DEF_COLS) begin
          if (!seen[wr_addr][wc_addr]) distinct++;
          seen[wr_addr][wc_addr] = 1'b1;
        end else begin
          bad++;
        end
        if (in_ready !== 1'b0) rdy_bad++;
      end
      if (in_ready === 1'b1) begin
        rdy_idx = idx;
        break;
      end
      tick();
    end
    check({tag, "_count"},    32'(nwr),             32'(n_exp));
    check({tag, "_first"},    32'(first),           32'(first_exp));
    check({tag, "_span"},     32'(last - first + 1), 32'(n_exp));
    check({tag, "_distinct"}, 32'(distinct),        32'(n_exp));
    check({tag, "_content"},  32'(bad),             32'd0);
    check({tag, "_ready_lo"}, 32'(rdy_bad),         32'd0);
    check({tag, "_ready_at"}, 32'(rdy_idx),         32'(last + 1));
    check_cur(tag, 0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ascii = 8'h00;
    fg_color = 3'b000;
    bg_color = 3'b000;
    tick();
    tick();

    // Reset values
    check("rst_we",    32'(we),         32'd0);
    check("rst_ready", 32'(in_ready),   32'd0);
    check("rst_busy",  32'(busy),       32'd1);
    check_cur("rst", 0, 0);
    check("rst_wr_addr", 32'(wr_addr),  32'd0);
    check("rst_wc_addr", 32'(wc_addr),  32'd0);
    check("rst_w_ascii", 32'(w_ascii),  32'd0);
    check("rst_w_fg",    32'(w_fg_color), 32'd0);
    check("rst_w_bg",    32'(w_bg_color), 32'd0);

    rst = 1'b0;
    run_clear("rst_clr", 2100, 3'b000, -1, 1);
    check("rst_clr_busy", 32'(busy), 32'd0);

    // Two printable bytes back to back
    send("A", 3'b010, 3'b001);
    check_wr("txt_A", 0, 0, "A");
    check("txt_A_fg", 32'(w_fg_color), 32'd2);
    check("txt_A_bg", 32'(w_bg_color), 32'd1);
    check_cur("txt_A", 0, 1);
    send("B", 3'b010, 3'b001);
    check_wr("txt_B", 0, 1, "B");
    check_cur("txt_B", 0, 2);

    // CR home, then a full row of 'x' wraps to the next line
    send(ASCII_CR, 3'b010, 3'b001);
    check("cr_no_we", 32'(we), 32'd0);
    check_cur("cr", 0, 0);
    for (int i = 0; i < 70; i++) send("x", 3'b010, 3'b001);
    check_wr("x_last", 0, 69, "x");
    check_cur("x_wrap", 1, 0);
    check("x_wrap_ready", 32'(in_ready), 32'd1);

    send("y", 3'b010, 3'b001);
    check_wr("y", 1, 0, "y");
    send(ASCII_CR, 3'b010, 3'b001);
    check("y_cr_no_we", 32'(we), 32'd0);
    check_cur("y_cr", 1, 0);
    send(ASCII_LF, 3'b010, 3'b001);
    check("lf_no_we", 32'(we), 32'd0);
    check_cur("lf", 2, 0);

    // Backspace mid-line and at column 0
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 3'b010, 3'b001);
    check_cur("abcde", 2, 5);
    send(ASCII_BS, 3'b010, 3'b001);
    check_wr("bs", 2, 4, ASCII_SP);
    check_cur("bs", 2, 4);
    send(ASCII_CR, 3'b010, 3'b001);
    send(ASCII_BS, 3'b010, 3'b001);
    check("bs0_no_we", 32'(we), 32'd0);
    check_cur("bs0", 2, 0);

    // An unknown control byte is swallowed
    send(8'h01, 3'b010, 3'b001);
    check("ctl_no_we", 32'(we), 32'd0);
    check_cur("ctl", 2, 0);

    // LF down to the last row never clears
    for (int i = 0; i < 27; i++) send(ASCII_LF, 3'b010, 3'b001);
    check("lf29_no_we", 32'(we),       32'd0);
    check("lf29_ready", 32'(in_ready), 32'd1);
    check_cur("lf29", 29, 0);

    // Screen wrap from the bottom-right cell
    for (int i = 0; i < 69; i++) send("q", 3'b010, 3'b001);
    check_cur("q_end", 29, 69);
    send("z", 3'b111, 3'b011);
    check_wr("z", 29, 69, "z");
    check("z_fg", 32'(w_fg_color), 32'd7);
    check("z_ready", 32'(in_ready), 32'd0);
    check_cur("z", 0, 0);
    tick();
    run_clear("wrap_clr", 70, 3'b011, 0, 0);

    // Form feed mid-line clears the screen in the latched background
    send("h", 3'b010, 3'b001);
    send("i", 3'b010, 3'b001);
    check_cur("hi", 0, 2);
    send(ASCII_FF, 3'b010, 3'b100);
    run_clear("ff_clr", 2100, 3'b100, -1, 0);

    // Reset part-way through a form-feed clear restarts with bg=0
    send("k", 3'b010, 3'b001);
    send(ASCII_FF, 3'b010, 3'b100);
    for (int i = 0; i < 1000; i++) tick();
    check("ff_mid_busy", 32'(busy), 32'd1);
    check("ff_mid_bg",   32'(w_bg_color), 32'd4);
    rst = 1'b1;
    tick();
    check("ff_rst_we",    32'(we),       32'd0);
    check("ff_rst_ready", 32'(in_ready), 32'd0);
    check("ff_rst_busy",  32'(busy),     32'd1);
    rst = 1'b0;
    run_clear("ff_rst_clr", 2100, 3'b000, -1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
